// File: rtl/tlul_socket_m1_rr_if.sv
// rtl/tlul_socket_m1_rr_if.sv - TL-UL link bundle: N parallel A channels sharing one D channel
interface tlul_socket_m1_rr_if #(
   parameter int N   = 1,
   parameter int AIW = 8
);
   logic [N-1:0]          a_valid;
   logic [N-1:0][2:0]     a_opcode;
   logic [N-1:0][2:0]     a_param;
   logic [N-1:0][1:0]     a_size;
   logic [N-1:0][AIW-1:0] a_source;
   logic [N-1:0][31:0]    a_address;
   logic [N-1:0][3:0]     a_mask;
   logic [N-1:0][31:0]    a_data;
   logic [N-1:0]          a_ready;

   // D payload is shared by every lane; only valid/ready are per lane
   logic [N-1:0]          d_valid;
   logic [2:0]            d_opcode;
   logic [2:0]            d_param;
   logic [1:0]            d_size;
   logic [AIW-1:0]        d_source;
   logic                  d_sink;
   logic [31:0]           d_data;
   logic                  d_error;
   logic [N-1:0]          d_ready;

   modport master (
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
      input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
   );

   modport slave (
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
      output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
   );
endinterface

// File: rtl/tlul_socket_m1_rr.sv
// rtl/tlul_socket_m1_rr.sv - TL-UL M:1 socket with arbiter, registered request slice and per-host outstanding limits
module tlul_socket_m1_rr #(
   parameter int M              = 4,
   parameter int MaxOutstanding = 8,
   parameter int ArbMode        = 0,
   parameter int AIW            = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   tlul_socket_m1_rr_if.slave  tl_h,
   tlul_socket_m1_rr_if.master tl_d,
   output logic [M-1:0]        idle_o
);
   localparam int STIDW = (M > 1) ? $clog2(M) : 1;
   localparam int IDW   = AIW;
   localparam int CW    = $clog2(MaxOutstanding + 1);

   logic [M-1:0]         eligible;
   logic [M-1:0][CW-1:0] cnt;
   logic [M-1:0]         inc;
   logic [M-1:0]         dec;
   logic [STIDW-1:0]     ptr;
   logic [STIDW-1:0]     gnt_idx;
   logic [STIDW-1:0]     rr_idx;
   logic [STIDW:0]       rr_sum;
   logic                 gnt_any;
   logic                 load;
   logic                 dev_accept;
   logic [STIDW-1:0]     rsp_idx;
   logic                 rsp_in_range;

   logic                 sl_valid;
   logic [2:0]           sl_opcode;
   logic [2:0]           sl_param;
   logic [1:0]           sl_size;
   logic [IDW-1:0]       sl_source;
   logic [31:0]          sl_address;
   logic [3:0]           sl_mask;
   logic [31:0]          sl_data;

   always_comb begin
      for (int i = 0; i < M; i++) begin
         eligible[i] = tl_h.a_valid[i] && (cnt[i] < CW'(MaxOutstanding));
      end
   end

   // Scan starts at ptr for round-robin, at 0 for fixed priority
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      rr_sum  = '0;
      rr_idx  = '0;
      for (int k = 0; k < M; k++) begin
         rr_sum = {1'b0, ptr} + (STIDW+1)'(k);
         if (rr_sum >= (STIDW+1)'(M)) begin
            rr_sum = rr_sum - (STIDW+1)'(M);
         end
         rr_idx = (ArbMode == 0) ? rr_sum[STIDW-1:0] : STIDW'(k);
         if (!gnt_any && eligible[rr_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = rr_idx;
         end
      end
   end

   assign dev_accept = sl_valid && tl_d.a_ready[0];
   assign load       = rst_ni && gnt_any && (!sl_valid || tl_d.a_ready[0]);

   always_comb begin
      for (int i = 0; i < M; i++) begin
         tl_h.a_ready[i] = load && (gnt_idx == STIDW'(i));
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sl_valid   <= 1'b0;
         sl_opcode  <= '0;
         sl_param   <= '0;
         sl_size    <= '0;
         sl_source  <= '0;
         sl_address <= '0;
         sl_mask    <= '0;
         sl_data    <= '0;
      end else if (load) begin
         sl_valid   <= 1'b1;
         sl_opcode  <= tl_h.a_opcode[gnt_idx];
         sl_param   <= tl_h.a_param[gnt_idx];
         sl_size    <= tl_h.a_size[gnt_idx];
         sl_source  <= {tl_h.a_source[gnt_idx][IDW-STIDW-1:0], gnt_idx};
         sl_address <= tl_h.a_address[gnt_idx];
         sl_mask    <= tl_h.a_mask[gnt_idx];
         sl_data    <= tl_h.a_data[gnt_idx];
      end else if (dev_accept) begin
         sl_valid   <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr <= '0;
      end else if (load) begin
         ptr <= (gnt_idx == STIDW'(M - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   assign tl_d.a_valid   = sl_valid;
   assign tl_d.a_opcode  = sl_opcode;
   assign tl_d.a_param   = sl_param;
   assign tl_d.a_size    = sl_size;
   assign tl_d.a_source  = sl_source;
   assign tl_d.a_address = sl_address;
   assign tl_d.a_mask    = sl_mask;
   assign tl_d.a_data    = sl_data;

   // Responses whose host index does not exist are accepted and dropped
   assign rsp_idx      = tl_d.d_source[STIDW-1:0];
   assign rsp_in_range = ({1'b0, rsp_idx} < (STIDW+1)'(M));

   always_comb begin
      for (int i = 0; i < M; i++) begin
         tl_h.d_valid[i] = rst_ni && tl_d.d_valid[0] && rsp_in_range && (rsp_idx == STIDW'(i));
      end
      tl_d.d_ready = rsp_in_range ? tl_h.d_ready[rsp_idx] : 1'b1;
   end

   assign tl_h.d_opcode = tl_d.d_opcode;
   assign tl_h.d_param  = tl_d.d_param;
   assign tl_h.d_size   = tl_d.d_size;
   assign tl_h.d_source = {{STIDW{1'b0}}, tl_d.d_source[IDW-1:STIDW]};
   assign tl_h.d_sink   = tl_d.d_sink;
   assign tl_h.d_data   = tl_d.d_data;
   assign tl_h.d_error  = tl_d.d_error;

   always_comb begin
      for (int i = 0; i < M; i++) begin
         inc[i] = load && (gnt_idx == STIDW'(i));
         dec[i] = tl_h.d_valid[i] && tl_h.d_ready[i];
      end
   end

   // Decrement saturates at 0 so stale responses after a reset cannot wrap a counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt <= '0;
      end else begin
         for (int i = 0; i < M; i++) begin
            if (inc[i] && !dec[i]) begin
               cnt[i] <= cnt[i] + 1'b1;
            end else if (dec[i] && !inc[i] && (cnt[i] != '0)) begin
               cnt[i] <= cnt[i] - 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < M; i++) begin
         idle_o[i] = (cnt[i] == '0);
      end
   end

   for (genvar gi = 0; gi < M; gi++) begin : g_cnt_chk
      a_cnt_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
         !(dec[gi] && !inc[gi] && (cnt[gi] == '0)));
   end
endmodule
